// File: rtl/gray_counter_bank.sv
// gray_counter_bank: CHANNELS independent WIDTH-bit Gray-coded counters.
// Each channel supports increment, decrement, binary load and Gray load.
// Value changes are queued in a 2-entry notification FIFO and presented on
// the indication interface with ENA/RDY handshake.
//
// Ports:
//   CLK, nRST                    clock, synchronous active-low reset
//   request_*__ENA               mutating methods (writeGray > writeBin > inc > dec)
//   request_op_ch / request_op_v target channel / write data
//   request_op__RDY              shared accept for mutating methods
//   request_readSel              channel for combinational reads
//   request_readBin/readGray     selected channel value (0 when out of range)
//   request_read__RDY            always 1
//   indication_value_ENA/ch/v    FIFO head
//   indication_value__RDY        consumer pops the head

package gray_counter_bank_pkg;
  typedef enum logic [1:0] {OP_INC, OP_DEC, OP_WBIN, OP_WGRAY} op_e;
endpackage

// One channel: Gray storage, binary decode and next-value arithmetic.
module gray_counter_lane
  import gray_counter_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             we,
  input  op_e              op,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_nxt,
  output logic             chg
);
  localparam logic [WIDTH-1:0] MAXV = '1;

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] wgray_bin;

  // Prefix XOR from the MSB down turns Gray into binary.
  always_comb begin
    bin       = '0;
    wgray_bin = '0;
    bin[WIDTH-1]       = gray_q[WIDTH-1];
    wgray_bin[WIDTH-1] = wdata[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      bin[i]       = bin[i+1] ^ gray_q[i];
      wgray_bin[i] = wgray_bin[i+1] ^ wdata[i];
    end
  end

  always_comb begin
    bin_nxt = bin;
    unique case (op)
      OP_INC:   bin_nxt = (SATURATE != 0 && bin == MAXV) ? bin : bin + 1'b1;
      OP_DEC:   bin_nxt = (SATURATE != 0 && bin == '0)   ? bin : bin - 1'b1;
      OP_WBIN:  bin_nxt = wdata;
      OP_WGRAY: bin_nxt = wgray_bin;
      default:  bin_nxt = bin;
    endcase
  end

  assign chg  = (bin_nxt != bin);
  assign gray = gray_q;

  always_ff @(posedge CLK) begin
    if (!nRST)   gray_q <= '0;
    else if (we) gray_q <= bin_nxt ^ (bin_nxt >> 1);
  end
endmodule

module gray_counter_bank
  import gray_counter_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int CHW      = 2,
  parameter int SATURATE = 0,
  parameter int NOTIFY   = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             request_increment__ENA,
  input  logic             request_decrement__ENA,
  input  logic             request_writeBin__ENA,
  input  logic             request_writeGray__ENA,
  input  logic [CHW-1:0]   request_op_ch,
  input  logic [WIDTH-1:0] request_op_v,
  output logic             request_op__RDY,
  input  logic [CHW-1:0]   request_readSel,
  output logic [WIDTH-1:0] request_readBin,
  output logic [WIDTH-1:0] request_readGray,
  output logic             request_read__RDY,
  output logic             indication_value__ENA,
  output logic [CHW-1:0]   indication_value_ch,
  output logic [WIDTH-1:0] indication_value_v,
  input  logic             indication_value__RDY
);
  op_e                               op;
  logic                              op_any, accept, ch_ok, push, pop, full;
  logic [CHANNELS-1:0]               we;
  logic [CHANNELS-1:0][WIDTH-1:0]    lane_gray, lane_bin, lane_nxt;
  logic [CHANNELS-1:0]               lane_chg;
  logic [WIDTH-1:0]                  sel_nxt;
  logic                              sel_chg;

  logic [1:0][CHW-1:0]               fifo_ch;
  logic [1:0][WIDTH-1:0]             fifo_v;
  logic                              rd_ptr, wr_ptr;
  logic [1:0]                        count;

  // Lower-priority simultaneous requests simply lose the encode.
  always_comb begin
    op = OP_DEC;
    if (request_writeGray__ENA)      op = OP_WGRAY;
    else if (request_writeBin__ENA)  op = OP_WBIN;
    else if (request_increment__ENA) op = OP_INC;
  end

  assign op_any = request_writeGray__ENA | request_writeBin__ENA |
                  request_increment__ENA | request_decrement__ENA;
  assign full   = (count == 2'd2);
  assign request_op__RDY   = (NOTIFY != 0) ? !full : 1'b1;
  assign request_read__RDY = 1'b1;
  assign accept = op_any && request_op__RDY;
  assign ch_ok  = int'(request_op_ch) < CHANNELS;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign we[i] = accept && (int'(request_op_ch) == i);
    gray_counter_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_lane (
      .CLK     (CLK),
      .nRST    (nRST),
      .we      (we[i]),
      .op      (op),
      .wdata   (request_op_v),
      .gray    (lane_gray[i]),
      .bin     (lane_bin[i]),
      .bin_nxt (lane_nxt[i]),
      .chg     (lane_chg[i])
    );
  end

  // Channel muxes written as loops so out-of-range indices fall to 0.
  always_comb begin
    sel_nxt          = '0;
    sel_chg          = 1'b0;
    request_readBin  = '0;
    request_readGray = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(request_op_ch) == i) begin
        sel_nxt = lane_nxt[i];
        sel_chg = lane_chg[i];
      end
      if (int'(request_readSel) == i) begin
        request_readBin  = lane_bin[i];
        request_readGray = lane_gray[i];
      end
    end
  end

  // accept already implies a free slot when NOTIFY is set.
  assign push = (NOTIFY != 0) && accept && ch_ok && sel_chg;
  assign pop  = indication_value__ENA && indication_value__RDY;

  assign indication_value__ENA = (count != 2'd0);
  assign indication_value_ch   = fifo_ch[rd_ptr];
  assign indication_value_v    = fifo_v[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_ch[wr_ptr] <= request_op_ch;
      fifo_v[wr_ptr]  <= sel_nxt;
    end
  end
endmodule

// File: tb/tb_gray_counter_bank.sv
// Drives a wrapping (index 0) and a saturating (index 1) instance with the
// same stimulus and compares both against a value/queue reference model.
module tb_gray_counter_bank;
  logic       clk = 1'b0;
  logic       nrst;
  logic       inc, dec, wbin, wgray;
  logic [1:0] op_ch;
  logic [3:0] op_v;
  logic [1:0] read_sel;
  logic       ind_rdy;

  logic       op_rdy_o   [2];
  logic [3:0] read_bin_o [2];
  logic [3:0] read_gray_o[2];
  logic       read_rdy_o [2];
  logic       ind_ena_o  [2];
  logic [1:0] ind_ch_o   [2];
  logic [3:0] ind_v_o    [2];

  int tests = 0;
  int fails = 0;

  // Reference state: binary value per channel, FIFO as an ordered list.
  int mv[2][4];
  int fq_ch[2][2];
  int fq_v[2][2];
  int fn[2];

  always #5 clk = ~clk;

  gray_counter_bank #(.WIDTH(4), .CHANNELS(4), .CHW(2), .SATURATE(0), .NOTIFY(1)) dut_w (
    .CLK(clk), .nRST(nrst),
    .request_increment__ENA(inc), .request_decrement__ENA(dec),
    .request_writeBin__ENA(wbin), .request_writeGray__ENA(wgray),
    .request_op_ch(op_ch), .request_op_v(op_v), .request_op__RDY(op_rdy_o[0]),
    .request_readSel(read_sel), .request_readBin(read_bin_o[0]),
    .request_readGray(read_gray_o[0]), .request_read__RDY(read_rdy_o[0]),
    .indication_value__ENA(ind_ena_o[0]), .indication_value_ch(ind_ch_o[0]),
    .indication_value_v(ind_v_o[0]), .indication_value__RDY(ind_rdy)
  );

  gray_counter_bank #(.WIDTH(4), .CHANNELS(4), .CHW(2), .SATURATE(1), .NOTIFY(1)) dut_s (
    .CLK(clk), .nRST(nrst),
    .request_increment__ENA(inc), .request_decrement__ENA(dec),
    .request_writeBin__ENA(wbin), .request_writeGray__ENA(wgray),
    .request_op_ch(op_ch), .request_op_v(op_v), .request_op__RDY(op_rdy_o[1]),
    .request_readSel(read_sel), .request_readBin(read_bin_o[1]),
    .request_readGray(read_gray_o[1]), .request_read__RDY(read_rdy_o[1]),
    .indication_value__ENA(ind_ena_o[1]), .indication_value_ch(ind_ch_o[1]),
    .indication_value_v(ind_v_o[1]), .indication_value__RDY(ind_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gray_to_bin(input int g);
    int r = 0;
    for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == g) r = b;
    return r;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      fn[d] = 0;
      for (int c = 0; c < 4; c++) mv[d][c] = 0;
    end
  endfunction

  // Applies one clock edge worth of behaviour to model d.
  function automatic void model_edge(input int d);
    bit rdy, acc;
    int old_v, new_v;
    if (!nrst) begin
      fn[d] = 0;
      for (int c = 0; c < 4; c++) mv[d][c] = 0;
      return;
    end
    rdy = (fn[d] < 2);
    acc = (inc | dec | wbin | wgray) && rdy;
    if (fn[d] > 0 && ind_rdy) begin
      fq_ch[d][0] = fq_ch[d][1];
      fq_v[d][0]  = fq_v[d][1];
      fn[d]--;
    end
    if (acc) begin
      old_v = mv[d][op_ch];
      if (wgray)     new_v = gray_to_bin(int'(op_v));
      else if (wbin) new_v = int'(op_v);
      else if (inc)  new_v = (old_v == 15) ? ((d == 1) ? 15 : 0) : old_v + 1;
      else           new_v = (old_v == 0)  ? ((d == 1) ? 0 : 15) : old_v - 1;
      mv[d][op_ch] = new_v;
      if (new_v != old_v) begin
        fq_ch[d][fn[d]] = int'(op_ch);
        fq_v[d][fn[d]]  = new_v;
        fn[d]++;
      end
    end
  endfunction

  task automatic check_outputs();
    int eb;
    for (int d = 0; d < 2; d++) begin
      eb = mv[d][read_sel];
      chk($sformatf("op_rdy[%0d]", d), op_rdy_o[d], (fn[d] < 2));
      chk($sformatf("read_rdy[%0d]", d), read_rdy_o[d], 1);
      chk($sformatf("read_bin[%0d] sel%0d", d, read_sel), read_bin_o[d], eb);
      chk($sformatf("read_gray[%0d] sel%0d", d, read_sel), read_gray_o[d], eb ^ (eb >> 1));
      chk($sformatf("ind_ena[%0d]", d), ind_ena_o[d], (fn[d] > 0));
      if (fn[d] > 0) begin
        chk($sformatf("ind_ch[%0d]", d), ind_ch_o[d], fq_ch[d][0]);
        chk($sformatf("ind_v[%0d]", d), ind_v_o[d], fq_v[d][0]);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle();
    inc = 0; dec = 0; wbin = 0; wgray = 0;
  endtask

  initial begin
    logic [3:0] prev_g;
    nrst = 0; idle(); op_ch = 0; op_v = 0; read_sel = 0; ind_rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    cycle();
    nrst = 1;

    // Reset state on every channel.
    for (int c = 0; c < 4; c++) begin
      read_sel = 2'(c);
      cycle();
    end

    // Wrapping increments on ch1; Gray steps by one bit each time.
    read_sel = 1; op_ch = 1; inc = 1;
    prev_g = read_gray_o[0];
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("gray_one_bit_step", $countones(read_gray_o[0] ^ prev_g), 1);
      prev_g = read_gray_o[0];
    end
    idle();
    chk("wrap_back_to_0", read_bin_o[0], 0);
    repeat (3) cycle();

    // Saturation ends on ch2.
    read_sel = 2; op_ch = 2;
    wbin = 1; op_v = 15; cycle(); idle();
    repeat (2) cycle();
    inc = 1; cycle(); idle();
    chk("sat_hold_max", read_bin_o[1], 15);
    chk("sat_no_notify_max", ind_ena_o[1], 0);
    wbin = 1; op_v = 0; cycle(); idle();
    repeat (2) cycle();
    dec = 1; cycle(); idle();
    chk("sat_hold_zero", read_bin_o[1], 0);
    chk("sat_no_notify_zero", ind_ena_o[1], 0);
    repeat (2) cycle();

    // Back-pressure on ch0.
    ind_rdy = 0; op_ch = 0; read_sel = 0; inc = 1;
    repeat (3) cycle();
    idle();
    chk("bp_stalled", op_rdy_o[0], 0);
    chk("bp_value", read_bin_o[0], 2);
    ind_rdy = 1;
    repeat (3) cycle();
    chk("bp_released", op_rdy_o[0], 1);

    // Collision: writeGray beats increment.
    op_ch = 3; read_sel = 3; op_v = 4'b1100; wgray = 1; inc = 1;
    cycle(); idle();
    chk("collision_bin", read_bin_o[0], 8);
    repeat (2) cycle();

    // Reset with a full FIFO and a request pending.
    ind_rdy = 0; op_ch = 0; read_sel = 0; inc = 1;
    repeat (2) cycle();
    nrst = 0;
    cycle();
    nrst = 1; idle();
    chk("rst_ind_empty", ind_ena_o[0], 0);
    chk("rst_counter_zero", read_bin_o[0], 0);
    ind_rdy = 1;
    repeat (3) cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      inc      = ($urandom_range(0, 3) == 0);
      dec      = ($urandom_range(0, 3) == 0);
      wbin     = ($urandom_range(0, 5) == 0);
      wgray    = ($urandom_range(0, 5) == 0);
      op_ch    = 2'($urandom_range(0, 3));
      op_v     = 4'($urandom_range(0, 15));
      read_sel = 2'($urandom_range(0, 3));
      ind_rdy  = ($urandom_range(0, 2) != 0);
      nrst     = ($urandom_range(0, 99) != 0);
      cycle();
    end
    nrst = 1; idle(); ind_rdy = 1;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
